// File: rtl/bcd_stopwatch.sv
`default_nettype none
// ============================================================================
// Module   : bcd_stopwatch
// Purpose  : Parametrised DIGITS-decade BCD stopwatch/timer with an internal
//            tick prescaler, up/down counting, preset load, clear and
//            terminal-count detection. Optional lap-hold display freeze is
//            enabled by defining BCD_STOPWATCH_LAP_HOLD_EN.
// Ports    : clk        - clock
//            reset      - synchronous, active-high reset
//            run        - counting enabled while high
//            clear      - pulse: zero count and prescaler, release lap hold
//            load       - pulse: load preset (nibbles >9 saturate to 9)
//            preset     - packed BCD load value, digit k at [4k+3:4k]
//            down       - 0 = count up, 1 = count down
//            lap        - pulse: lap freeze toggle (lap-hold build only)
//            digits     - packed BCD display value
//            tick       - one-cycle pulse when a stepped value first shows
//            wrap       - pulse with tick when all-9s rolls to all-0s
//            done       - high while down=1 and count==0
//            lap_active - high while the display is frozen
// Revision : 1.0 - initial release
// ============================================================================
module bcd_stopwatch #(
  parameter int DIGITS   = 4,
  parameter int TICK_DIV = 1000000,
  parameter int CNT_W    = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                run,
  input  logic                clear,
  input  logic                load,
  input  logic [4*DIGITS-1:0] preset,
  input  logic                down,
  input  logic                lap,
  output logic [4*DIGITS-1:0] digits,
  output logic                tick,
  output logic                wrap,
  output logic                done,
  output logic                lap_active
);

  localparam int               W          = 4 * DIGITS;
  localparam logic [CNT_W-1:0] PRESC_LAST = CNT_W'(TICK_DIV - 1);

  logic [W-1:0]     count_q, count_d;
  logic [CNT_W-1:0] presc_q, presc_d;
  logic             tick_q, tick_d;
  logic             wrap_q, wrap_d;

  logic [W-1:0]     count_inc;
  logic [W-1:0]     count_dec;
  logic [W-1:0]     preset_sat;
  logic             count_zero;
  logic             count_all9;
  logic             carry;
  logic             borrow;

  // Ripple BCD increment/decrement of the live count plus preset saturation.
  always_comb begin
    count_inc  = count_q;
    count_dec  = count_q;
    preset_sat = preset;
    count_all9 = 1'b1;
    carry      = 1'b1;
    borrow     = 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
      if (count_q[4*k +: 4] != 4'd9) begin
        count_all9 = 1'b0;
      end
      if (preset[4*k +: 4] > 4'd9) begin
        preset_sat[4*k +: 4] = 4'd9;
      end
      if (carry) begin
        if (count_q[4*k +: 4] >= 4'd9) begin
          count_inc[4*k +: 4] = 4'd0;
        end else begin
          count_inc[4*k +: 4] = count_q[4*k +: 4] + 4'd1;
          carry               = 1'b0;
        end
      end
      if (borrow) begin
        if (count_q[4*k +: 4] == 4'd0) begin
          count_dec[4*k +: 4] = 4'd9;
        end else begin
          count_dec[4*k +: 4] = count_q[4*k +: 4] - 4'd1;
          borrow              = 1'b0;
        end
      end
    end
  end

  assign count_zero = (count_q == '0);

  // Next-state: clear > load > counting. Down-counting at zero parks the
  // prescaler at 0 so the counter never underflows.
  always_comb begin
    count_d = count_q;
    presc_d = presc_q;
    tick_d  = 1'b0;
    wrap_d  = 1'b0;
    if (clear) begin
      count_d = '0;
      presc_d = '0;
    end else if (load) begin
      count_d = preset_sat;
      presc_d = '0;
    end else if (down && count_zero) begin
      presc_d = '0;
    end else if (run) begin
      if (presc_q == PRESC_LAST) begin
        presc_d = '0;
        tick_d  = 1'b1;
        wrap_d  = !down && count_all9;
        count_d = down ? count_dec : count_inc;
      end else begin
        presc_d = presc_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
      presc_q <= '0;
      tick_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      presc_q <= presc_d;
      tick_q  <= tick_d;
      wrap_q  <= wrap_d;
    end
  end

  assign tick = tick_q;
  assign wrap = wrap_q;
  assign done = down & count_zero;

`ifdef BCD_STOPWATCH_LAP_HOLD_EN
  logic         lap_q, lap_d;
  logic [W-1:0] snap_q, snap_d;

  // Lap capture uses count_q, i.e. the value before any step on this edge.
  always_comb begin
    lap_d  = lap_q;
    snap_d = snap_q;
    if (clear) begin
      lap_d = 1'b0;
    end else if (lap) begin
      if (!lap_q) begin
        lap_d  = 1'b1;
        snap_d = count_q;
      end else begin
        lap_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lap_q  <= 1'b0;
      snap_q <= '0;
    end else begin
      lap_q  <= lap_d;
      snap_q <= snap_d;
    end
  end

  assign digits     = lap_q ? snap_q : count_q;
  assign lap_active = lap_q;
`else
  logic unused_lap;
  assign unused_lap = lap;
  assign digits     = count_q;
  assign lap_active = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_bcd_stopwatch.sv
`default_nettype none
// ============================================================================
// Module   : tb_bcd_stopwatch
// Purpose  : Self-checking bench for bcd_stopwatch (DIGITS=4, TICK_DIV=4).
//            An integer-valued reference model tracks the count; a compare
//            process checks every output each cycle, and directed scenarios
//            pin literal values. Lap-hold checks are active when
//            BCD_STOPWATCH_LAP_HOLD_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bcd_stopwatch;

  localparam int D    = 4;
  localparam int TD   = 4;
  localparam int CW   = 8;
  localparam int MAXV = 9999;

  logic          clk    = 1'b0;
  logic          reset  = 1'b1;
  logic          run    = 1'b0;
  logic          clear  = 1'b0;
  logic          load   = 1'b0;
  logic [4*D-1:0] preset = '0;
  logic          down   = 1'b0;
  logic          lap    = 1'b0;
  logic [4*D-1:0] digits;
  logic          tick, wrap, done, lap_active;

  int checks = 0;
  int errors = 0;

  // Reference model state (count as a plain integer).
  int mv = 0, mp = 0, ms = 0;
  bit mt = 0, mw = 0, ml = 0, valid = 0;

  always #5 clk = ~clk;

  bcd_stopwatch #(.DIGITS(D), .TICK_DIV(TD), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .run(run), .clear(clear), .load(load),
    .preset(preset), .down(down), .lap(lap), .digits(digits),
    .tick(tick), .wrap(wrap), .done(done), .lap_active(lap_active)
  );

  function automatic logic [4*D-1:0] to_bcd(input int v);
    logic [4*D-1:0] r;
    int p;
    r = '0;
    p = 1;
    for (int k = 0; k < D; k++) begin
      r[4*k +: 4] = 4'((v / p) % 10);
      p = p * 10;
    end
    return r;
  endfunction

  function automatic int sat_val(input logic [4*D-1:0] b);
    int v, p, n;
    v = 0;
    p = 1;
    for (int k = 0; k < D; k++) begin
      n = int'(b[4*k +: 4]);
      if (n > 9) n = 9;
      v = v + n * p;
      p = p * 10;
    end
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: updated from the inputs seen at each rising edge.
  always @(posedge clk) begin : model
    int v, p, s;
    bit t, w, l;
    v = mv; p = mp; s = ms; l = ml; t = 0; w = 0;
    if (reset) begin
      v = 0; p = 0; s = 0; l = 0;
    end else begin
`ifdef BCD_STOPWATCH_LAP_HOLD_EN
      if (clear) l = 0;
      else if (lap) begin
        if (!l) begin s = v; l = 1; end
        else l = 0;
      end
`endif
      if (clear) begin
        v = 0; p = 0;
      end else if (load) begin
        v = sat_val(preset); p = 0;
      end else if (down && v == 0) begin
        p = 0;
      end else if (run) begin
        if (p == TD - 1) begin
          p = 0; t = 1;
          if (down) v = v - 1;
          else if (v == MAXV) begin v = 0; w = 1; end
          else v = v + 1;
        end else begin
          p = p + 1;
        end
      end
    end
    mv <= v; mp <= p; ms <= s; ml <= l; mt <= t; mw <= w;
    valid <= valid | reset;
  end

  // Compare every cycle, away from the active edge.
  always @(negedge clk) begin
    if (valid) begin
      check("digits", 32'(digits), 32'(ml ? to_bcd(ms) : to_bcd(mv)));
      check("tick", 32'(tick), 32'(mt));
      check("wrap", 32'(wrap), 32'(mw));
      check("done", 32'(done), 32'(down && mv == 0));
      check("lap_active", 32'(lap_active), 32'(ml));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // Literal pin: both DUT and model must show the hand-computed value.
  task automatic pin(input string name, input logic [4*D-1:0] lit);
    check({name, "_dut"}, 32'(digits), 32'(lit));
    check({name, "_model"}, 32'(ml ? to_bcd(ms) : to_bcd(mv)), 32'(lit));
  endtask

  initial begin
    reset = 1'b1; run = 1'b1; down = 1'b0;
    cyc(2);
    check("reset_digits", 32'(digits), 32'h0);
    check("reset_tick", 32'(tick), 32'h0);
    check("reset_wrap", 32'(wrap), 32'h0);
    check("reset_lap", 32'(lap_active), 32'h0);
    reset = 1'b0;

    // Up counting from reset.
    cyc(3);
    check("t1_no_tick_early", 32'(tick), 32'h0);
    cyc(1);
    pin("t1_first", 16'h0001);
    check("t1_tick", 32'(tick), 32'h1);
    cyc(36);
    pin("t1_ten", 16'h0010);

    // Wrap from all 9s.
    preset = 16'h9999; load = 1'b1; cyc(1); load = 1'b0;
    pin("t2_load", 16'h9999);
    cyc(4);
    pin("t2_wrap", 16'h0000);
    check("t2_tick", 32'(tick), 32'h1);
    check("t2_wrap", 32'(wrap), 32'h1);
    cyc(1);
    check("t2_tick_low", 32'(tick), 32'h0);
    check("t2_wrap_low", 32'(wrap), 32'h0);

    // Down counting to zero and holding.
    down = 1'b1; preset = 16'h0002; load = 1'b1; cyc(1); load = 1'b0;
    cyc(4);
    pin("t3_one", 16'h0001);
    cyc(4);
    pin("t3_zero", 16'h0000);
    check("t3_done", 32'(done), 32'h1);
    cyc(20);
    pin("t3_hold", 16'h0000);
    check("t3_no_tick", 32'(tick), 32'h0);

    // Pause/resume and clear on a terminal edge.
    down = 1'b0; clear = 1'b1; cyc(1); clear = 1'b0;
    cyc(2);
    run = 1'b0; cyc(10);
    run = 1'b1; cyc(1);
    check("t4_no_tick_resume", 32'(tick), 32'h0);
    cyc(1);
    pin("t4_resume_step", 16'h0001);
    check("t4_tick", 32'(tick), 32'h1);
    cyc(3);
    clear = 1'b1; cyc(1); clear = 1'b0;
    pin("t4_clear", 16'h0000);
    check("t4_clear_no_tick", 32'(tick), 32'h0);

    // Saturating load and clear-beats-load.
    preset = 16'h12F9; load = 1'b1; cyc(1); load = 1'b0;
    pin("t5_sat", 16'h1299);
    preset = 16'h4321; load = 1'b1; clear = 1'b1; cyc(1);
    load = 1'b0; clear = 1'b0;
    pin("t5_clear_wins", 16'h0000);

`ifdef BCD_STOPWATCH_LAP_HOLD_EN
    clear = 1'b1; cyc(1); clear = 1'b0;
    cyc(20);
    pin("t6_five", 16'h0005);
    lap = 1'b1; cyc(1); lap = 1'b0;
    pin("t6_frozen", 16'h0005);
    check("t6_lap_on", 32'(lap_active), 32'h1);
    cyc(11);
    check("t6_still_frozen", 32'(digits), 32'h0005);
    check("t6_model_live", 32'(to_bcd(mv)), 32'h0008);
    lap = 1'b1; cyc(1); lap = 1'b0;
    pin("t6_release", 16'h0008);
    check("t6_lap_off", 32'(lap_active), 32'h0);
`endif

    // Randomised phase, checked every cycle by the compare process.
    for (int i = 0; i < 4000; i++) begin
      run   = ($urandom % 8) != 0;
      if (($urandom % 64) == 0) down = ~down;
      clear = ($urandom % 100) == 0;
      load  = ($urandom % 40) == 0;
      lap   = ($urandom % 30) == 0;
      reset = ($urandom % 700) == 0;
      case ($urandom % 3)
        0:       preset = 16'($urandom);
        1:       preset = {12'h999, 4'($urandom)};
        default: preset = {12'h000, 4'($urandom % 4)};
      endcase
      cyc(1);
    end
    reset = 1'b0; clear = 1'b0; load = 1'b0; lap = 1'b0;
    cyc(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bcd_stopwatch.md
Name: bcd_stopwatch

Overview:
- Parametrised BCD stopwatch/timer that generalises the 4-digit up-only stopwatch to DIGITS decades.
- Has an internal tick prescaler, up/down mode, preset load, clear, and terminal-count detection.
- Feeds the 7-segment display multiplexer with packed BCD digits and pulses for downstream event logic.

Parameters:
DIGITS, 4, number of BCD decades (1..8); digit 0 is least significant.
TICK_DIV, 1000000, clk cycles per count step (>=2).
CNT_W, 32, prescaler width; must satisfy 2^CNT_W > TICK_DIV.

Ports:
clk  in  1  clock.
reset  in  1  synchronous, active-high.
run  in  1  level; counting enabled while high.
clear  in  1  1-cycle pulse; zero all digits and prescaler.
load  in  1  1-cycle pulse; load preset into digits.
preset  in  4*DIGITS  packed BCD load value; digit k at [4k+3:4k].
down  in  1  0 = count up, 1 = count down.
lap  in  1  1-cycle pulse; lap freeze toggle (optional feature only).
digits  out  4*DIGITS  packed BCD display value.
tick  out  1  1-cycle pulse; high in the first cycle a stepped value is visible.
wrap  out  1  1-cycle pulse, coincident with tick, when up-count rolls all-9s to all-0s.
done  out  1  level; high while down=1 and count==0.
lap_active  out  1  high while the display is frozen.

Behaviour:
- Reset: count digits=0, prescaler=0, tick=0, wrap=0, lap_active=0, digits=0. done follows its formula (1 if down=1).
- Priority per edge: reset > clear > load > counting.
- clear: count=0, prescaler=0, lap_active=0; run state is unaffected.
- load: count=preset with any nibble >9 saturated to 9; prescaler=0; lap state kept.
- Prescaler:
  - Increments while run=1 and no clear/load.
  - At TICK_DIV-1 it returns to 0 and the count steps on that same edge.
  - run=0 holds the prescaler (pause resumes mid-period, no reset).
- Up step:
  - Ripple BCD increment; a digit at 9 becomes 0 and carries.
  - All digits 9 -> all 0, with wrap=1 alongside tick.
- Down step:
  - Ripple BCD decrement; a digit at 0 becomes 9 and borrows.
  - At count==0 the counter does not step; prescaler held at 0, tick=0, so there is no underflow.
- done is derived combinationally from registered state (down & count==0), with zero added latency.
- tick and wrap are registered: high exactly one cycle, the cycle the new value first appears on digits.
- Changing down mid-period takes effect at the next step; the prescaler is not disturbed.
- Simultaneous clear with a step edge: clear wins, no tick. Same for load.
- run toggling in the same cycle as a prescaler terminal edge: the step is sampled with run as seen on that edge.

Optional Feature:
- Macro: BCD_STOPWATCH_LAP_HOLD_EN.
- Defined:
  - A lap pulse while lap_active=0 latches the current count into a snapshot; digits shows the snapshot and lap_active=1.
  - The next lap pulse releases it (digits live again, lap_active=0).
  - The internal count, tick, wrap and done continue unaffected.
  - clear releases the lap hold. load does not release the hold, but the snapshot is unchanged.
  - lap coinciding with a step captures the pre-step value.
- Undefined: lap ignored, lap_active tied 0, digits always live, no snapshot registers.

Test Plan:
1. DIGITS=4, TICK_DIV=4, down=0, run=1 from reset -> digits 0001 after 4 clks; tick pulses every 4th cycle; 0010 after 40 clks.
2. load preset=9999, down=0, run=1 -> after 4 clks digits=0000, tick=1 and wrap=1 same cycle, both low next cycle.
3. load preset=0002, down=1, run=1 -> 0001 at +4 clks, 0000 at +8 with done=1; held at 0000, no further tick for 20 clks.
4. run=1 for 2 clks, run=0 for 10 clks, run=1 -> first step 2 clks after resume; clear asserted on a terminal edge -> digits=0000, no tick.
5. load preset=12F9 -> digits=1299; load plus clear same cycle -> digits=0000.
6. (LAP_HOLD_EN) count to 0005, lap pulse -> digits stays 0005, lap_active=1 while count reaches 0008; second lap -> digits=0008, lap_active=0.
